// File: rtl/line_fill_buffer_if.sv
// Handshake bundle between the line fill buffer, the cache controller,
// main memory and imem.
interface line_fill_buffer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              drain_cl;
    logic              re_mm;
    logic [ADDR_W-1:0] addr_mm;
    logic [DATA_W-1:0] data_mm;
    logic              mem_valid_mm;
    logic              full_cl;
    logic              we_imem;
    logic [ADDR_W-1:0] addr_imem;
    logic [DATA_W-1:0] data_imem;
    logic              fill_done;
    logic              busy;

    modport slave (
        input  fill_req, fill_addr, drain_cl, data_mm, mem_valid_mm,
        output re_mm, addr_mm, full_cl, we_imem, addr_imem, data_imem, fill_done, busy
    );

    modport master (
        output fill_req, fill_addr, drain_cl, data_mm, mem_valid_mm,
        input  re_mm, addr_mm, full_cl, we_imem, addr_imem, data_imem, fill_done, busy
    );
endinterface

// File: rtl/line_fill_buffer.sv
// Cache-line fill engine: fetches one line from main memory word by word,
// then writes the buffered line into imem one word per cycle.
module line_fill_buffer #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    line_fill_buffer_if.slave  bus
);
    localparam int unsigned WCNT_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned BYTE_OFF = $clog2(DATA_W / 8);
    localparam int unsigned OFF      = WCNT_W + BYTE_OFF;
    localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] line_buf [WORDS_PER_LINE];
    logic [ADDR_W-1:0] word_addr;
    logic              unused_fill_addr_low;

    // base has its low OFF bits cleared, so OR-ing the word offset never carries
    assign word_addr = base | (ADDR_W'(wcnt) << BYTE_OFF);
    assign unused_fill_addr_low = ^bus.fill_addr[OFF-1:0];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state    <= IDLE;
            wcnt     <= '0;
            base     <= '0;
            line_buf <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fill_req) begin
                        base  <= {bus.fill_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        wcnt  <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_valid_mm) begin
                        line_buf[wcnt] <= bus.data_mm;
                        if (wcnt == LAST) begin
                            wcnt  <= '0;
                            state <= FULL;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.drain_cl) begin
                        wcnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wcnt == LAST) begin
                        wcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.re_mm     = 1'b0;
        bus.addr_mm   = '0;
        bus.full_cl   = 1'b0;
        bus.we_imem   = 1'b0;
        bus.addr_imem = '0;
        bus.data_imem = '0;
        bus.fill_done = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            FETCH: begin
                bus.re_mm   = 1'b1;
                bus.addr_mm = word_addr;
            end
            FULL: bus.full_cl = 1'b1;
            DRAIN: begin
                bus.we_imem   = 1'b1;
                bus.addr_imem = word_addr;
                bus.data_imem = line_buf[wcnt];
                bus.fill_done = (wcnt == LAST);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_line_fill_buffer.sv
// Self-checking bench for line_fill_buffer: 4-word instance for most scenarios,
// 8-word instance for the top-of-address-space line.
module tb_line_fill_buffer;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic clr;
    always #5 clk = ~clk;

    line_fill_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
    line_fill_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus8 ();

    line_fill_buffer #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(4)) dut4 (
        .clk(clk), .reset(reset), .clr(clr), .bus(bus4.slave));
    line_fill_buffer #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(8)) dut8 (
        .clk(clk), .reset(reset), .clr(clr), .bus(bus8.slave));

    int checks   = 0;
    int failures = 0;

    // Reference model: line base address and the words memory has delivered.
    logic [31:0] cur_base;
    logic [31:0] exp_line [8];

    function automatic logic [31:0] line_base(input logic [31:0] a, input int unsigned words);
        return a & ~(32'(words * 4) - 32'd1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus4.fill_req = 0; bus4.fill_addr = '0; bus4.drain_cl = 0;
        bus4.data_mm = '0; bus4.mem_valid_mm = 0;
        bus8.fill_req = 0; bus8.fill_addr = '0; bus8.drain_cl = 0;
        bus8.data_mm = '0; bus8.mem_valid_mm = 0;
    endtask

    task automatic start_fill(input logic [31:0] addr);
        cur_base = line_base(addr, 4);
        bus4.fill_addr = addr;
        bus4.fill_req  = 1;
        step();
        bus4.fill_req  = 0;
        bus4.fill_addr = $urandom;
    endtask

    // Serve words k0..k1, each answered lat cycles after its address appears.
    task automatic fetch_range(input int k0, input int k1, input int lat);
        for (int k = k0; k <= k1; k++) begin
            for (int c = 0; c < lat; c++) begin
                checks++;
                if (bus4.re_mm !== 1'b1 || bus4.addr_mm !== cur_base + 32'(4 * k)) begin
                    failures++;
                    $display("FAIL fetch_addr word %0d cyc %0d: re_mm=%b addr_mm=%h, expected re_mm=1 addr_mm=%h",
                             k, c, bus4.re_mm, bus4.addr_mm, cur_base + 32'(4 * k));
                end
                if (c == lat - 1) begin
                    exp_line[k] = $urandom;
                    bus4.data_mm = exp_line[k];
                    bus4.mem_valid_mm = 1;
                end
                step();
            end
            bus4.mem_valid_mm = 0;
            bus4.data_mm = '0;
        end
    endtask

    task automatic check_full(input string tag);
        checks++;
        if (bus4.full_cl !== 1'b1 || bus4.re_mm !== 1'b0 || bus4.addr_mm !== '0 ||
            bus4.busy !== 1'b1 || bus4.we_imem !== 1'b0) begin
            failures++;
            $display("FAIL %s full: full_cl=%b re_mm=%b addr_mm=%h busy=%b we_imem=%b, expected 1 0 0 1 0",
                     tag, bus4.full_cl, bus4.re_mm, bus4.addr_mm, bus4.busy, bus4.we_imem);
        end
    endtask

    task automatic drain_and_check(input string tag);
        bus4.drain_cl = 1;
        step();
        bus4.drain_cl = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus4.we_imem !== 1'b1 || bus4.addr_imem !== cur_base + 32'(4 * k) ||
                bus4.data_imem !== exp_line[k] || bus4.fill_done !== (k == 3)) begin
                failures++;
                $display("FAIL %s drain word %0d: we=%b addr=%h data=%h done=%b, expected we=1 addr=%h data=%h done=%b",
                         tag, k, bus4.we_imem, bus4.addr_imem, bus4.data_imem, bus4.fill_done,
                         cur_base + 32'(4 * k), exp_line[k], k == 3);
            end
            step();
        end
        checks++;
        if (bus4.busy !== 1'b0 || bus4.we_imem !== 1'b0 || bus4.fill_done !== 1'b0 ||
            bus4.full_cl !== 1'b0 || bus4.addr_imem !== '0) begin
            failures++;
            $display("FAIL %s after_drain: busy=%b we=%b done=%b full=%b addr_imem=%h, expected all 0",
                     tag, bus4.busy, bus4.we_imem, bus4.fill_done, bus4.full_cl, bus4.addr_imem);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus4.re_mm, bus4.addr_mm, bus4.full_cl, bus4.we_imem, bus4.addr_imem,
             bus4.data_imem, bus4.fill_done, bus4.busy} !== '0) begin
            failures++;
            $display("FAIL %s outputs: re=%b amm=%h full=%b we=%b aim=%h dim=%h done=%b busy=%b, expected all 0",
                     tag, bus4.re_mm, bus4.addr_mm, bus4.full_cl, bus4.we_imem, bus4.addr_imem,
                     bus4.data_imem, bus4.fill_done, bus4.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        check_all_zero("reset_initial");
        reset = 0;
        step();
        for (int tgt = 0; tgt < 3; tgt++) begin
            start_fill($urandom);
            if (tgt >= 1) begin
                fetch_range(0, 3, 1);
                if (tgt == 2) begin
                    bus4.drain_cl = 1;
                    step();
                    bus4.drain_cl = 0;
                end
            end else begin
                fetch_range(0, 0, 1);
            end
            reset = 1;
            step();
            check_all_zero($sformatf("reset_state%0d_first", tgt));
            step();
            step();
            reset = 0;
            step();
            check_all_zero($sformatf("reset_state%0d_after", tgt));
        end
    endtask

    task automatic test_fill();
        start_fill(32'h0000_1234);
        checks++;
        if (cur_base !== 32'h0000_1230) begin
            failures++;
            $display("FAIL fill_base model=%h expected 00001230", cur_base);
        end
        fetch_range(0, 3, 2);
        check_full("fill_1234");
        drain_and_check("fill_1234");
        for (int it = 0; it < 6; it++) begin
            start_fill($urandom);
            fetch_range(0, 3, $urandom_range(1, 4));
            check_full("fill_rand");
            // Stray requests while FULL must not alter state or buffer.
            repeat ($urandom_range(0, 3)) begin
                bus4.fill_req = 1;
                bus4.mem_valid_mm = 1;
                bus4.data_mm = $urandom;
                step();
            end
            bus4.fill_req = 0;
            bus4.mem_valid_mm = 0;
            check_full("fill_rand_wait");
            drain_and_check("fill_rand");
            bus4.drain_cl = 1;
            bus4.mem_valid_mm = 1;
            step();
            bus4.drain_cl = 0;
            bus4.mem_valid_mm = 0;
            check_all_zero("idle_ignores_drain_valid");
        end
    endtask

    task automatic test_back_to_back();
        start_fill($urandom);
        bus4.mem_valid_mm = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus4.re_mm !== 1'b1 || bus4.addr_mm !== cur_base + 32'(4 * k)) begin
                failures++;
                $display("FAIL b2b_addr word %0d: re_mm=%b addr_mm=%h, expected 1 %h",
                         k, bus4.re_mm, bus4.addr_mm, cur_base + 32'(4 * k));
            end
            exp_line[k] = 32'hA0 + 32'(k);
            bus4.data_mm = exp_line[k];
            step();
        end
        check_full("b2b");
        bus4.data_mm = 32'hA4;
        step();
        bus4.mem_valid_mm = 0;
        check_full("b2b_fifth_valid");
        drain_and_check("b2b");
    endtask

    task automatic test_ignored_in_fetch();
        logic [31:0] first_base;
        start_fill($urandom);
        first_base = cur_base;
        for (int phase = 0; phase < 2; phase++) begin
            repeat (2) begin
                bus4.fill_req = 1;
                bus4.drain_cl = 1;
                bus4.fill_addr = ~first_base;
                step();
                checks++;
                if (bus4.addr_mm !== first_base + 32'(4 * phase) || bus4.re_mm !== 1'b1 ||
                    bus4.we_imem !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_ignore phase %0d: addr_mm=%h re=%b we=%b, expected %h 1 0",
                             phase, bus4.addr_mm, bus4.re_mm, bus4.we_imem, first_base + 32'(4 * phase));
                end
            end
            bus4.fill_req = 0;
            bus4.drain_cl = 0;
            fetch_range(phase, phase, 1);
        end
        fetch_range(2, 3, 3);
        check_full("fetch_ignore");
        drain_and_check("fetch_ignore");
    endtask

    task automatic test_clr();
        start_fill($urandom);
        fetch_range(0, 1, 2);
        clr = 1;
        bus4.mem_valid_mm = 1;
        step();
        clr = 0;
        check_all_zero("clr_mid_fetch");
        // Late response after the abort lands in IDLE and is dropped.
        step();
        bus4.mem_valid_mm = 0;
        check_all_zero("clr_late_valid");
        start_fill(32'h0000_0040);
        fetch_range(0, 3, $urandom_range(1, 3));
        check_full("clr_refill");
        drain_and_check("clr_refill");
    endtask

    task automatic test_wide_line();
        logic [31:0] b8;
        b8 = line_base(32'hFFFF_FFFC, 8);
        bus8.fill_addr = 32'hFFFF_FFFC;
        bus8.fill_req = 1;
        step();
        bus8.fill_req = 0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus8.re_mm !== 1'b1 || bus8.addr_mm !== b8 + 32'(4 * k)) begin
                failures++;
                $display("FAIL wide_addr word %0d: re=%b addr_mm=%h, expected 1 %h",
                         k, bus8.re_mm, bus8.addr_mm, b8 + 32'(4 * k));
            end
            exp_line[k] = $urandom;
            bus8.data_mm = exp_line[k];
            bus8.mem_valid_mm = 1;
            step();
            bus8.mem_valid_mm = 0;
        end
        checks++;
        if (bus8.full_cl !== 1'b1 || bus8.re_mm !== 1'b0) begin
            failures++;
            $display("FAIL wide_full: full_cl=%b re=%b, expected 1 0", bus8.full_cl, bus8.re_mm);
        end
        bus8.drain_cl = 1;
        step();
        bus8.drain_cl = 0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus8.we_imem !== 1'b1 || bus8.addr_imem !== b8 + 32'(4 * k) ||
                bus8.data_imem !== exp_line[k] || bus8.fill_done !== (k == 7)) begin
                failures++;
                $display("FAIL wide_drain word %0d: we=%b addr=%h data=%h done=%b, expected 1 %h %h %b",
                         k, bus8.we_imem, bus8.addr_imem, bus8.data_imem, bus8.fill_done,
                         b8 + 32'(4 * k), exp_line[k], k == 7);
            end
            step();
        end
        checks++;
        if (bus8.busy !== 1'b0) begin
            failures++;
            $display("FAIL wide_idle: busy=%b expected 0", bus8.busy);
        end
    endtask

    initial begin
        reset = 1;
        clr = 0;
        idle_inputs();
        test_reset();
        test_fill();
        test_back_to_back();
        test_ignored_in_fetch();
        test_clr();
        test_wide_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
